// File: rtl/zigzag_pkg.sv
// Shared types and defaults for the generalised rail-fence decryptor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package zigzag_pkg;

  localparam int DEF_D_WIDTH   = 8;
  localparam int DEF_KEY_WIDTH = 16;
  localparam int MIN_KEY       = 2;

  // Controller states; explicit encodings keep the register image stable
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_PREFIX = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/zigzag_rail_gen.sv
// Up/down rail index generator walking 0,1..K-1,K-2..1,0,... one step per advance.
// Latency: rail_o is registered; it reflects clear/advance one cycle later.
// Backpressure: none; steps only when advance_i is high, clear_i has priority.
module zigzag_rail_gen
  import zigzag_pkg::*;
#(
  parameter int W = DEF_KEY_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         advance_i,
  input  logic [W-1:0] key_i,
  output logic [W-1:0] rail_o
);

  localparam logic [W-1:0] MIN_KEY_W = W'(MIN_KEY);

  logic [W-1:0] rail_q, rail_d;
  logic         down_q, down_d;

  // Next rail: bounce at rail K-1 going down and at rail 0 going up
  always_comb begin
    rail_d = rail_q;
    down_d = down_q;
    if (clear_i) begin
      rail_d = '0;
      down_d = 1'b1;
    end else if (advance_i) begin
      if (key_i < MIN_KEY_W) begin
        rail_d = '0;
        down_d = 1'b1;
      end else if (down_q) begin
        if (rail_q == key_i - 1'b1) begin
          rail_d = rail_q - 1'b1;
          down_d = 1'b0;
        end else begin
          rail_d = rail_q + 1'b1;
        end
      end else begin
        if (rail_q == '0) begin
          rail_d = rail_q + 1'b1;
          down_d = 1'b1;
        end else begin
          rail_d = rail_q - 1'b1;
        end
      end
    end
  end

  // Rail position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rail_q <= '0;
      down_q <= 1'b1;
    end else begin
      rail_q <= rail_d;
      down_q <= down_d;
    end
  end

  assign rail_o = rail_q;

endmodule

// File: rtl/zigzag_decryption_n.sv
// Rail-fence decryptor for 2..MAX_KEY rails: buffer message, on token count rows, prefix-sum starts, stream plaintext.
// Latency: first valid_o n+K+1 cycles after the token edge (1 cycle in identity mode), then n back-to-back characters.
// Backpressure: none on output; input is ignored while busy, characters beyond the buffer are dropped and flagged.
module zigzag_decryption_n
  import zigzag_pkg::*;
#(
  parameter int                 D_WIDTH                = DEF_D_WIDTH,
  parameter int                 KEY_WIDTH              = DEF_KEY_WIDTH,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter int                 MAX_KEY                = 8,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 overflow
);

  localparam int AW = $clog2(MAX_NOF_CHARS);
  localparam int RW = $clog2(MAX_KEY);
  localparam logic [KEY_WIDTH-1:0] MIN_KEY_W   = KEY_WIDTH'(MIN_KEY);
  localparam logic [KEY_WIDTH-1:0] MAX_KEY_W   = KEY_WIDTH'(MAX_KEY);
  localparam logic [KEY_WIDTH-1:0] MAX_CHARS_W = KEY_WIDTH'(MAX_NOF_CHARS);

  state_t               state_q;
  logic [KEY_WIDTH-1:0] n_q;      // characters buffered
  logic [KEY_WIDTH-1:0] p_q;      // position in COUNT/EMIT, row index in PREFIX
  logic [KEY_WIDTH-1:0] key_q;
  logic                 ident_q;  // key out of range: emit buffer in order
  logic                 busy_q;
  logic                 valid_q;
  logic [D_WIDTH-1:0]   data_q;
  logic                 ovf_q;

  logic [D_WIDTH-1:0]   buf_q   [MAX_NOF_CHARS];
  logic [KEY_WIDTH-1:0] len_q   [MAX_KEY];
  logic [KEY_WIDTH-1:0] start_q [MAX_KEY];
  logic [KEY_WIDTH-1:0] cnt_q   [MAX_KEY];

  logic [KEY_WIDTH-1:0] rail;
  logic [RW-1:0]        rail_idx;
  logic [RW-1:0]        pre_idx;
  logic [RW-1:0]        pre_prev;
  logic [KEY_WIDTH-1:0] rd_addr;
  logic [AW-1:0]        rd_idx;
  logic [AW-1:0]        wr_idx;
  logic                 tok;
  logic                 key_ok;
  logic                 rail_clear;
  logic                 rail_adv;

  // Index narrowing and control strobes; out-of-range indices fold to 0 and never occur by construction
  always_comb begin
    rail_idx = '0;
    if (rail < MAX_KEY_W) rail_idx = rail[RW-1:0];
    pre_idx = '0;
    if (p_q < MAX_KEY_W) pre_idx = p_q[RW-1:0];
    pre_prev = pre_idx - 1'b1;
    rd_addr  = ident_q ? p_q : (start_q[rail_idx] + cnt_q[rail_idx]);
    rd_idx   = '0;
    if (rd_addr < MAX_CHARS_W) rd_idx = rd_addr[AW-1:0];
    wr_idx = '0;
    if (n_q < MAX_CHARS_W) wr_idx = n_q[AW-1:0];
    tok        = valid_i && (data_i == START_DECRYPTION_TOKEN);
    key_ok     = (key >= MIN_KEY_W) && (key <= MAX_KEY_W);
    rail_clear = ((state_q == ST_IDLE) && tok) || (state_q == ST_PREFIX);
    rail_adv   = (state_q == ST_COUNT) ||
                 ((state_q == ST_EMIT) && !ident_q && (p_q < n_q));
  end

  zigzag_rail_gen #(
    .W (KEY_WIDTH)
  ) u_rail (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (rail_clear),
    .advance_i (rail_adv),
    .key_i     (key_q),
    .rail_o    (rail)
  );

  // Controller: buffer, count row lengths, prefix-sum row starts, emit plaintext
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      p_q     <= '0;
      key_q   <= '0;
      ident_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
      for (int r = 0; r < MAX_KEY; r++) begin
        len_q[r]   <= '0;
        start_q[r] <= '0;
        cnt_q[r]   <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          data_q  <= '0;
          if (tok) begin
            key_q  <= key;
            busy_q <= 1'b1;
            p_q    <= '0;
            for (int r = 0; r < MAX_KEY; r++) len_q[r] <= '0;
            if (key_ok) begin
              ident_q <= 1'b0;
              state_q <= (n_q == '0) ? ST_PREFIX : ST_COUNT;
            end else begin
              ident_q <= 1'b1;
              state_q <= ST_EMIT;
            end
          end else if (valid_i) begin
            if (n_q < MAX_CHARS_W) begin
              buf_q[wr_idx] <= data_i;
              n_q           <= n_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end

        ST_COUNT: begin
          len_q[rail_idx] <= len_q[rail_idx] + 1'b1;
          if (p_q == n_q - 1'b1) begin
            p_q     <= '0;
            state_q <= ST_PREFIX;
          end else begin
            p_q <= p_q + 1'b1;
          end
        end

        ST_PREFIX: begin
          start_q[pre_idx] <= (p_q == '0) ? '0 : (start_q[pre_prev] + len_q[pre_prev]);
          cnt_q[pre_idx]   <= '0;
          if (p_q == key_q - 1'b1) begin
            p_q <= '0;
            if (n_q == '0) begin
              busy_q  <= 1'b0;
              ovf_q   <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_EMIT;
            end
          end else begin
            p_q <= p_q + 1'b1;
          end
        end

        ST_EMIT: begin
          if (p_q < n_q) begin
            valid_q <= 1'b1;
            data_q  <= buf_q[rd_idx];
            if (!ident_q) cnt_q[rail_idx] <= cnt_q[rail_idx] + 1'b1;
            p_q <= p_q + 1'b1;
          end else begin
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            n_q     <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign overflow = ovf_q;

endmodule
